// File: rtl/xfire_cordic_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : xfire_cordic_iter_if
//  Purpose  : Input/output handshake bundle for the iterative CORDIC engine.
//  Revision : 1.0  initial release
// ============================================================================
interface xfire_cordic_iter_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic               in_mode;
    logic [WIDTH-1:0]   in_x;
    logic [WIDTH-1:0]   in_y;
    logic [WIDTH-1:0]   in_z;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH+1:0]   out_x;
    logic [WIDTH+1:0]   out_y;
    logic [WIDTH-1:0]   out_z;

    modport master (
        output in_valid, in_mode, in_x, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z
    );

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z
    );
endinterface
`default_nettype wire

// File: rtl/xfire_cordic_iter.sv
`default_nettype none
// ============================================================================
//  Module   : xfire_cordic_iter
//  Purpose  : Iterative CORDIC (rotation/vectoring), one micro-rotation/cycle.
//  Revision : 1.0  initial release
// ============================================================================
module xfire_cordic_iter #(
    parameter int WIDTH = 16,
    parameter int ITERS = 14
) (
    input  wire logic           clk,
    input  wire logic           arst_n,
    input  wire logic           srst,
    input  wire logic           enable,
    xfire_cordic_iter_if.slave  bus
);
    localparam int XW = WIDTH + 2;
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0]          c_LAST = IW'(ITERS);
    localparam logic signed [WIDTH-1:0] c_QTR = $signed({2'b01, {(WIDTH-2){1'b0}}});

    // atan(2^-i) with 2^31 == pi, rescaled with rounding to 2^(WIDTH-1) == pi
    localparam logic [31:0] c_ATAN32 [0:30] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1
    };

    function automatic logic [WIDTH-1:0] f_atan(input int idx);
        logic [32:0] t;
        t = {1'b0, c_ATAN32[idx]} + ((33'd1 << (32 - WIDTH)) >> 1);
        return t[32-WIDTH +: WIDTH];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_i;
    logic                   r_mode;
    logic signed [XW-1:0]   r_x, r_y;
    logic [WIDTH-1:0]       r_z;
    logic                   r_out_valid;
    logic signed [XW-1:0]   r_out_x, r_out_y;
    logic [WIDTH-1:0]       r_out_z;

    logic [WIDTH-1:0]       w_atan_tab [ITERS];
    logic [WIDTH-1:0]       w_atan;
    logic signed [XW-1:0]   w_xe, w_ye, w_px, w_py;
    logic [WIDTH-1:0]       w_pz;
    logic signed [XW-1:0]   w_xs, w_ys, w_x_nxt, w_y_nxt;
    logic [WIDTH-1:0]       w_z_nxt;
    logic                   w_dpos;
    logic                   w_in_ready;

    for (genvar g = 0; g < ITERS; g++) begin : g_atan
        assign w_atan_tab[g] = f_atan(g);
    end

    always_comb begin
        w_atan = '0;
        for (int k = 0; k < ITERS; k++) begin
            if (r_i == IW'(k)) w_atan = w_atan_tab[k];
        end
    end

    assign w_in_ready = enable && (r_state == S_IDLE);

    // Quadrant pre-rotation brings the operand into the +/-pi/2 convergence range
    assign w_xe = {{2{bus.in_x[WIDTH-1]}}, bus.in_x};
    assign w_ye = {{2{bus.in_y[WIDTH-1]}}, bus.in_y};

    always_comb begin
        w_px = w_xe;
        w_py = w_ye;
        w_pz = bus.in_z;
        if (!bus.in_mode) begin
            if ($signed(bus.in_z) >= c_QTR) begin
                w_px = -w_ye;
                w_py = w_xe;
                w_pz = bus.in_z - c_QTR;
            end else if ($signed(bus.in_z) < -c_QTR) begin
                w_px = w_ye;
                w_py = -w_xe;
                w_pz = bus.in_z + c_QTR;
            end
        end else if (bus.in_x[WIDTH-1]) begin
            if (!bus.in_y[WIDTH-1]) begin
                w_px = w_ye;
                w_py = -w_xe;
                w_pz = bus.in_z + c_QTR;
            end else begin
                w_px = -w_ye;
                w_py = w_xe;
                w_pz = bus.in_z - c_QTR;
            end
        end
    end

    assign w_dpos  = r_mode ? r_y[XW-1] : ~r_z[WIDTH-1];
    assign w_xs    = r_x >>> r_i;
    assign w_ys    = r_y >>> r_i;
    assign w_x_nxt = w_dpos ? (r_x - w_ys) : (r_x + w_ys);
    assign w_y_nxt = w_dpos ? (r_y + w_xs) : (r_y - w_xs);
    assign w_z_nxt = w_dpos ? (r_z - w_atan) : (r_z + w_atan);

    // Counter reaching ITERS marks the extra cycle that registers the result
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_mode      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
        end else if (srst) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_mode      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
        end else if (enable) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && w_in_ready) begin
                        r_mode  <= bus.in_mode;
                        r_x     <= w_px;
                        r_y     <= w_py;
                        r_z     <= w_pz;
                        r_i     <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_i == c_LAST) begin
                        r_out_x     <= r_x;
                        r_out_y     <= r_y;
                        r_out_z     <= r_z;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_x <= w_x_nxt;
                        r_y <= w_y_nxt;
                        r_z <= w_z_nxt;
                        r_i <= r_i + 1'b1;
                    end
                end
                S_DONE: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.out_z     = r_out_z;
endmodule
`default_nettype wire
